// File: rtl/proc_pkg.sv
// Shared processor definitions: operand-stack command encodings and sequencer state type.
package proc_pkg;

   localparam logic [1:0] STACK_OP_PUSH  = 2'b00;
   localparam logic [1:0] STACK_OP_POP   = 2'b01;
   localparam logic [1:0] STACK_OP_POP2  = 2'b10;
   localparam logic [1:0] STACK_OP_CLEAR = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_RD_A,
      ST_RD_B,
      ST_WAIT,
      ST_RESP
   } stack_state_t;

endpackage

// File: rtl/stack_ctrl.sv
// Operand-stack sequencer: executes PUSH/POP/POP2/CLEAR against an external
// single-port synchronous RAM and tracks the stack pointer and sticky error flags.
module stack_ctrl
   import proc_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 16,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   input  logic [1:0]        cmd_op,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              cmd_ready,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [DATA_W-1:0] rsp_tos,
   output logic [DATA_W-1:0] rsp_nos,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned SP_W = ADDR_W + 1;

   stack_state_t      state_q, state_d;
   logic [SP_W-1:0]   sp_q, sp_d;
   logic              pop2_q, pop2_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0] rsp_tos_q, rsp_tos_d;
   logic [DATA_W-1:0] rsp_nos_q, rsp_nos_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_wren_q, mem_wren_d;

   logic full_c, empty_c, lt2_c;

   assign full_c  = (sp_q == SP_W'(DEPTH));
   assign empty_c = (sp_q == SP_W'(0));
   assign lt2_c   = (sp_q < SP_W'(2));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Rejected commands go straight to RESP so the RAM is never touched.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               case (cmd_op)
                  STACK_OP_PUSH: state_d = full_c  ? ST_RESP : ST_WRITE;
                  STACK_OP_POP:  state_d = empty_c ? ST_RESP : ST_RD_A;
                  STACK_OP_POP2: state_d = lt2_c   ? ST_RESP : ST_RD_A;
                  default:       state_d = ST_RESP;
               endcase
            end
         end
         ST_WRITE: state_d = ST_RESP;
         ST_RD_A:  state_d = pop2_q ? ST_RD_B : ST_WAIT;
         ST_RD_B:  state_d = ST_WAIT;
         ST_WAIT:  state_d = ST_RESP;
         ST_RESP:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output registers are loaded from the state being entered, so they line up with it.
   always_comb begin
      sp_d        = sp_q;
      pop2_d      = pop2_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      cmd_ready_d = (state_d == ST_IDLE);
      rsp_valid_d = (state_d == ST_RESP);
      rsp_err_d   = 1'b0;
      rsp_tos_d   = rsp_tos_q;
      rsp_nos_d   = rsp_nos_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wren_d  = (state_d == ST_WRITE);

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               pop2_d = (cmd_op == STACK_OP_POP2);
               case (cmd_op)
                  STACK_OP_PUSH: begin
                     if (full_c) begin
                        overflow_d = 1'b1;
                        rsp_err_d  = 1'b1;
                     end else begin
                        mem_addr_d  = ADDR_W'(sp_q);
                        mem_wdata_d = cmd_data;
                     end
                  end
                  STACK_OP_POP: begin
                     if (empty_c) begin
                        underflow_d = 1'b1;
                        rsp_err_d   = 1'b1;
                     end else begin
                        mem_addr_d = ADDR_W'(sp_q - SP_W'(1));
                     end
                  end
                  STACK_OP_POP2: begin
                     if (lt2_c) begin
                        underflow_d = 1'b1;
                        rsp_err_d   = 1'b1;
                     end else begin
                        mem_addr_d = ADDR_W'(sp_q - SP_W'(1));
                     end
                  end
                  default: begin
                     sp_d        = SP_W'(0);
                     overflow_d  = 1'b0;
                     underflow_d = 1'b0;
                  end
               endcase
            end
         end
         ST_WRITE: sp_d = sp_q + SP_W'(1);
         ST_RD_A: begin
            if (pop2_q) begin
               mem_addr_d = ADDR_W'(sp_q - SP_W'(2));
            end
         end
         ST_RD_B: rsp_tos_d = mem_rdata;
         ST_WAIT: begin
            if (pop2_q) begin
               rsp_nos_d = mem_rdata;
               sp_d      = sp_q - SP_W'(2);
            end else begin
               rsp_tos_d = mem_rdata;
               sp_d      = sp_q - SP_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sp_q        <= '0;
         pop2_q      <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_tos_q   <= '0;
         rsp_nos_q   <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wren_q  <= 1'b0;
      end else begin
         sp_q        <= sp_d;
         pop2_q      <= pop2_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_tos_q   <= rsp_tos_d;
         rsp_nos_q   <= rsp_nos_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wren_q  <= mem_wren_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_tos   = rsp_tos_q;
   assign rsp_nos   = rsp_nos_q;
   assign count     = sp_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wren  = mem_wren_q;

endmodule
